// File: rtl/dna_read_arb.sv
// rtl/dna_read_arb.sv - Round-robin arbiter and sequencer for the device-DNA shift port
module dna_read_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DNA_WIDTH = 57,
    parameter int CACHE_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   refresh,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 done,
    output logic [DNA_WIDTH-1:0] id,
    output logic                 id_valid,
    output logic                 busy,
    output logic                 dna_read,
    output logic                 dna_shift,
    input  logic                 dna_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (DNA_WIDTH > 1) ? $clog2(DNA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DNA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [NUM_REQ-1:0]   grant_next;
    logic [IDX_W-1:0]     rr, rr_next;
    logic [IDX_W-1:0]     win_q, win_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    // Only the bits captured before the final shift are kept; the last bit
    // comes straight from dna_dout when the full value is committed to id.
    logic [DNA_WIDTH-2:0] id_sr, id_sr_next;
    logic [DNA_WIDTH-1:0] id_next;
    logic                 id_valid_next;

    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W:0]       cand_sum;
    logic [IDX_W-1:0]     cand;

    // Round-robin pick, next-state and next-value logic for the whole sequencer
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        rr_next       = rr;
        win_next      = win_q;
        cnt_next      = cnt;
        id_sr_next    = id_sr;
        id_next       = id;
        id_valid_next = id_valid;
        found         = 1'b0;
        pick          = '0;
        cand_sum      = '0;
        cand          = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr} + (IDX_W + 1)'(k);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_next       = '0;
                    grant_next[pick] = 1'b1;
                    win_next         = pick;
                    if ((CACHE_EN != 0) && id_valid && !refresh[pick]) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_next   = '0;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                id_sr_next = {id_sr[DNA_WIDTH-3:0], dna_dout};
                if (cnt == LAST_BIT) begin
                    cnt_next      = '0;
                    id_next       = {id_sr, dna_dout};
                    id_valid_next = 1'b1;
                    state_next    = S_DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DONE: begin
                rr_next    = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state_next == S_IDLE) begin
            grant_next = '0;
        end
    end

    // State register with outputs registered as decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            dna_read  <= 1'b0;
            dna_shift <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            done      <= (state_next == S_DONE);
            busy      <= (state_next != S_IDLE);
            dna_read  <= (state_next == S_READ);
            dna_shift <= (state_next == S_SHIFT);
        end
    end

    // Arbitration pointer, shift counter, capture register and cached id
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= '0;
            win_q    <= '0;
            cnt      <= '0;
            id_sr    <= '0;
            id       <= '0;
            id_valid <= 1'b0;
        end else begin
            rr       <= rr_next;
            win_q    <= win_next;
            cnt      <= cnt_next;
            id_sr    <= id_sr_next;
            id       <= id_next;
            id_valid <= id_valid_next;
        end
    end

endmodule

// File: tb/tb_dna_read_arb.sv
// tb/tb_dna_read_arb.sv - Randomized self-checking bench for dna_read_arb
module tb_dna_read_arb;

    localparam int N = 4;
    localparam int W = 57;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [N-1:0] req_a       [2];
    logic [N-1:0] refresh_a   [2];
    logic [N-1:0] grant_a     [2];
    logic         done_a      [2];
    logic [W-1:0] id_a        [2];
    logic         id_valid_a  [2];
    logic         busy_a      [2];
    logic         dna_read_a  [2];
    logic         dna_shift_a [2];
    logic         dna_dout_a  [2];
    logic [W-1:0] dna_value   [2];

    bit           m_valid [2];
    logic [W-1:0] m_id    [2];
    int           m_rr    [2];

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0 caches, instance 1 re-reads on every request; each has its own DNA port model
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [W-1:0] port_sr;

        dna_read_arb #(
            .NUM_REQ   (N),
            .DNA_WIDTH (W),
            .CACHE_EN  ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req_a[g]),
            .refresh   (refresh_a[g]),
            .grant     (grant_a[g]),
            .done      (done_a[g]),
            .id        (id_a[g]),
            .id_valid  (id_valid_a[g]),
            .busy      (busy_a[g]),
            .dna_read  (dna_read_a[g]),
            .dna_shift (dna_shift_a[g]),
            .dna_dout  (dna_dout_a[g])
        );

        // DNA port: READ loads the value, SHIFT moves the next bit to DOUT
        always @(posedge clk) begin
            if (dna_read_a[g]) begin
                port_sr <= dna_value[g];
            end else if (dna_shift_a[g]) begin
                port_sr <= {port_sr[W-2:0], 1'b0};
            end
        end

        assign dna_dout_a[g] = port_sr[W-1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int u);
        check("rst_grant",     64'(grant_a[u]),     64'(0));
        check("rst_done",      64'(done_a[u]),      64'(0));
        check("rst_id",        64'(id_a[u]),        64'(0));
        check("rst_id_valid",  64'(id_valid_a[u]),  64'(0));
        check("rst_busy",      64'(busy_a[u]),      64'(0));
        check("rst_dna_read",  64'(dna_read_a[u]),  64'(0));
        check("rst_dna_shift", 64'(dna_shift_a[u]), 64'(0));
    endtask

    // Drive a request set at a negedge with the DUT idle and serve it to completion,
    // predicting each grant from the round-robin rule and cache state.
    task automatic serve(input int u, input logic [N-1:0] reqs, input logic [N-1:0] refr,
                         input bit drop, input logic [N-1:0] late);
        logic [N-1:0] pend;
        logic [N-1:0] oh;
        int  w, cyc, reads, shifts, overlap, exp_lat;
        bit  rd;
        bit  ce;
        ce = (u == 0);
        pend = reqs;
        req_a[u] = reqs;
        refresh_a[u] = refr;
        while (pend != 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr[u] + k) % N;
                if (w < 0 && pend[c]) w = c;
            end
            rd = !(ce && m_valid[u] && !refr[w]);
            exp_lat = rd ? W + 2 : 1;
            oh = '0;
            oh[w] = 1'b1;
            cyc = 0; reads = 0; shifts = 0; overlap = 0;
            do begin
                @(negedge clk);
                cyc++;
                reads   += int'(dna_read_a[u]);
                shifts  += int'(dna_shift_a[u]);
                overlap += int'(dna_read_a[u] && dna_shift_a[u]);
                if (drop && rd && cyc == 3) req_a[u][w] = 1'b0;
                if (cyc == 5 && late != 0) begin
                    req_a[u] = req_a[u] | late;
                    pend = pend | late;
                    late = '0;
                end
            end while (!done_a[u] && cyc < 200);
            check("done_seen", 64'(done_a[u]), 64'(1));
            check("latency",   64'(cyc),       64'(exp_lat));
            check("grant",     64'(grant_a[u]), 64'(oh));
            check("busy",      64'(busy_a[u]),  64'(1));
            check("reads",     64'(reads),      64'(rd ? 1 : 0));
            check("shifts",    64'(shifts),     64'(rd ? W : 0));
            check("overlap",   64'(overlap),    64'(0));
            if (rd) begin
                m_id[u] = dna_value[u];
                m_valid[u] = 1'b1;
            end
            check("id",       64'(id_a[u]),       64'(m_id[u]));
            check("id_valid", 64'(id_valid_a[u]), 64'(m_valid[u]));
            m_rr[u] = (w + 1) % N;
            pend[w] = 1'b0;
            refr[w] = 1'b0;
            req_a[u][w] = 1'b0;
            refresh_a[u][w] = 1'b0;
            @(negedge clk);
            check("idle_grant", 64'(grant_a[u]), 64'(0));
            check("idle_busy",  64'(busy_a[u]),  64'(0));
            check("done_pulse", 64'(done_a[u]),  64'(0));
            if (cyc >= 200) begin
                pend = '0;
                req_a[u] = '0;
                refresh_a[u] = '0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] r, f, l;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_a[u] = '0;
            refresh_a[u] = '0;
            dna_value[u] = W'({$urandom, $urandom});
            m_valid[u] = 1'b0;
            m_id[u] = '0;
            m_rr[u] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk);

        // First read, then a cached hit, then park the pointer at 1
        dna_value[0] = 57'h1EDCBA987654321;
        serve(0, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        serve(0, 4'b0100, 4'b0000, 1'b0, 4'b0000);
        serve(0, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        serve(0, 4'b1111, 4'b0000, 1'b0, 4'b0000);

        // Forced re-read picks up a changed DNA value
        dna_value[0] = 57'h0123456789ABCDE;
        serve(0, 4'b0010, 4'b0010, 1'b0, 4'b0000);

        // Reset in the middle of SHIFT discards the read and clears the cache
        dna_value[0] = W'({$urandom, $urandom});
        req_a[0] = 4'b0001;
        refresh_a[0] = 4'b0001;
        repeat (21) @(negedge clk);
        check("mid_shift", 64'(dna_shift_a[0]), 64'(1));
        rst = 1'b1;
        req_a[0] = '0;
        refresh_a[0] = '0;
        @(negedge clk);
        check_reset(0);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 1'b0;
            m_id[u] = '0;
            m_rr[u] = 0;
        end
        @(negedge clk);
        serve(0, 4'b0001, 4'b0000, 1'b0, 4'b0000);

        // Random request sets, refreshes, dropped and late requests
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 2) == 0) dna_value[0] = W'({$urandom, $urandom});
            r = N'($urandom_range(1, 15));
            f = N'($urandom) & N'($urandom);
            l = N'($urandom) & ~r;
            if ($urandom_range(0, 1) == 0) l = '0;
            serve(0, r, f, ($urandom_range(0, 3) == 0), l);
        end

        // Without caching every request re-reads the port
        dna_value[1] = W'({$urandom, $urandom});
        serve(1, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        dna_value[1] = W'({$urandom, $urandom});
        serve(1, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        dna_value[1] = W'({$urandom, $urandom});
        serve(1, 4'b0110, 4'b0000, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
